// File: rtl/mmc_pkg.sv
// ============================================================================
// Module   : mmc_pkg
// Brief    : Shared types and helpers for multi_mode_game_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmc_pkg;

  typedef enum logic [1:0] {
    MODE_UP1 = 2'b00,
    MODE_UPB = 2'b01,
    MODE_DN1 = 2'b10,
    MODE_DNB = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    WHO_NONE = 2'b00,
    WHO_LOSE = 2'b01,
    WHO_WIN  = 2'b10
  } who_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  // Width needed to hold the larger of the two score limits.
  function automatic int score_width(input int win_limit, input int lose_limit);
    int m;
    m = (win_limit > lose_limit) ? win_limit : lose_limit;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmc_sat_step.sv
// ============================================================================
// Module   : mmc_sat_step
// Brief    : Combinational saturating add/sub of a step, with entry flags for
//            the MAX and zero boundaries.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmc_sat_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] step,
  input  logic             down,
  output logic [WIDTH-1:0] nxt,
  output logic             hit_max,
  output logic             hit_zero
);

  localparam logic [WIDTH-1:0] c_max = '1;

  always_comb begin
    nxt = cur;
    if (down) begin
      nxt = (cur >= step) ? (cur - step) : '0;
    end else begin
      nxt = (cur <= (c_max - step)) ? (cur + step) : c_max;
    end
  end

  // Entry only: sitting on a boundary does not raise the flag again.
  assign hit_max  = (nxt == c_max) && (cur != c_max);
  assign hit_zero = (nxt == '0)    && (cur != '0);

endmodule

`default_nettype wire

// File: rtl/multi_mode_game_counter.sv
// ============================================================================
// Module   : multi_mode_game_counter
// Brief    : Saturating multi-mode game counter with win/lose tallies and a
//            timed GAMEOVER state. Define MMC_SCORE_OUT_EN to expose the
//            score counters as win_count / lose_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_mode_game_counter
  import mmc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int BIG_STEP    = 2,
  parameter int WIN_LIMIT   = 15,
  parameter int LOSE_LIMIT  = 15,
  parameter int OVER_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       control_value,
  input  logic             init,
  input  logic [WIDTH-1:0] count_input,
  output logic             winner,
  output logic             loser,
  output logic             gameover,
  output logic [1:0]       who,
  output logic [WIDTH-1:0] count
`ifdef MMC_SCORE_OUT_EN
  ,
  output logic [score_width(WIN_LIMIT, LOSE_LIMIT)-1:0] win_count,
  output logic [score_width(WIN_LIMIT, LOSE_LIMIT)-1:0] lose_count
`endif
);

  localparam int c_sw = score_width(WIN_LIMIT, LOSE_LIMIT);
  localparam int c_tw = $clog2(OVER_CYCLES + 1);

  localparam logic [c_sw-1:0]  c_win_lim  = c_sw'(WIN_LIMIT);
  localparam logic [c_sw-1:0]  c_lose_lim = c_sw'(LOSE_LIMIT);
  localparam logic [c_tw-1:0]  c_tmr_last = c_tw'(OVER_CYCLES - 1);
  localparam logic [WIDTH-1:0] c_big      = WIDTH'(BIG_STEP);
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [c_sw-1:0]  r_win_cnt, w_win_cnt_nxt;
  logic [c_sw-1:0]  r_lose_cnt, w_lose_cnt_nxt;
  logic [c_tw-1:0]  r_timer, w_timer_nxt;
  logic             r_winner, w_winner_nxt;
  logic             r_loser, w_loser_nxt;
  logic             r_gameover, w_gameover_nxt;
  logic [1:0]       r_who, w_who_nxt;

  mode_e            w_mode;
  logic [WIDTH-1:0] w_step;
  logic             w_down;
  logic [WIDTH-1:0] w_sat;
  logic             w_hit_max;
  logic             w_hit_zero;

  assign w_mode = mode_e'(control_value);
  assign w_step = ((w_mode == MODE_UPB) || (w_mode == MODE_DNB)) ? c_big : c_one;
  assign w_down = (w_mode == MODE_DN1) || (w_mode == MODE_DNB);

  mmc_sat_step #(
    .WIDTH (WIDTH)
  ) u_sat_step (
    .cur      (r_count),
    .step     (w_step),
    .down     (w_down),
    .nxt      (w_sat),
    .hit_max  (w_hit_max),
    .hit_zero (w_hit_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_RUN;
      r_count    <= '0;
      r_win_cnt  <= '0;
      r_lose_cnt <= '0;
      r_timer    <= '0;
      r_winner   <= 1'b0;
      r_loser    <= 1'b0;
      r_gameover <= 1'b0;
      r_who      <= WHO_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_win_cnt  <= w_win_cnt_nxt;
      r_lose_cnt <= w_lose_cnt_nxt;
      r_timer    <= w_timer_nxt;
      r_winner   <= w_winner_nxt;
      r_loser    <= w_loser_nxt;
      r_gameover <= w_gameover_nxt;
      r_who      <= w_who_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_win_cnt_nxt  = r_win_cnt;
    w_lose_cnt_nxt = r_lose_cnt;
    w_timer_nxt    = r_timer;
    w_winner_nxt   = 1'b0;
    w_loser_nxt    = 1'b0;
    w_gameover_nxt = r_gameover;
    w_who_nxt      = r_who;

    case (r_state)
      ST_RUN: begin
        if (init) begin
          w_count_nxt = count_input;
        end else if (en) begin
          w_count_nxt  = w_sat;
          w_winner_nxt = w_hit_max;
          w_loser_nxt  = w_hit_zero;
        end

        // The pulse is still emitted on the edge that ends the game.
        if (w_winner_nxt) begin
          w_win_cnt_nxt = r_win_cnt + 1'b1;
          if ((r_win_cnt + 1'b1) == c_win_lim) begin
            w_state_nxt    = ST_OVER;
            w_gameover_nxt = 1'b1;
            w_who_nxt      = WHO_WIN;
            w_timer_nxt    = '0;
          end
        end else if (w_loser_nxt) begin
          w_lose_cnt_nxt = r_lose_cnt + 1'b1;
          if ((r_lose_cnt + 1'b1) == c_lose_lim) begin
            w_state_nxt    = ST_OVER;
            w_gameover_nxt = 1'b1;
            w_who_nxt      = WHO_LOSE;
            w_timer_nxt    = '0;
          end
        end
      end

      ST_OVER: begin
        if (r_timer == c_tmr_last) begin
          w_state_nxt    = ST_RUN;
          w_gameover_nxt = 1'b0;
          w_who_nxt      = WHO_NONE;
          w_win_cnt_nxt  = '0;
          w_lose_cnt_nxt = '0;
          w_timer_nxt    = '0;
          w_count_nxt    = init ? count_input : '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign winner   = r_winner;
  assign loser    = r_loser;
  assign gameover = r_gameover;
  assign who      = r_who;
  assign count    = r_count;

`ifdef MMC_SCORE_OUT_EN
  assign win_count  = r_win_cnt;
  assign lose_count = r_lose_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_mode_game_counter.sv
// ============================================================================
// Module   : tb_multi_mode_game_counter
// Brief    : Scoreboard bench for multi_mode_game_counter against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_mode_game_counter;

  localparam int WIDTH       = 4;
  localparam int BIG_STEP    = 2;
  localparam int WIN_LIMIT   = 3;
  localparam int LOSE_LIMIT  = 2;
  localparam int OVER_CYCLES = 3;
  localparam int MAXV        = (1 << WIDTH) - 1;
  localparam int SW          = mmc_pkg::score_width(WIN_LIMIT, LOSE_LIMIT);

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [1:0]       control_value;
  logic             init;
  logic [WIDTH-1:0] count_input;
  logic             winner;
  logic             loser;
  logic             gameover;
  logic [1:0]       who;
  logic [WIDTH-1:0] count;
`ifdef MMC_SCORE_OUT_EN
  logic [SW-1:0]    win_count;
  logic [SW-1:0]    lose_count;
`endif

  multi_mode_game_counter #(
    .WIDTH       (WIDTH),
    .BIG_STEP    (BIG_STEP),
    .WIN_LIMIT   (WIN_LIMIT),
    .LOSE_LIMIT  (LOSE_LIMIT),
    .OVER_CYCLES (OVER_CYCLES)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en),
    .control_value (control_value),
    .init          (init),
    .count_input   (count_input),
    .winner        (winner),
    .loser         (loser),
    .gameover      (gameover),
    .who           (who),
    .count         (count)
`ifdef MMC_SCORE_OUT_EN
    ,
    .win_count     (win_count),
    .lose_count    (lose_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit winner;
    bit loser;
    bit gameover;
    int who;
    int wins;
    int loses;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state: plain game rules, no encoding details.
  int m_count, m_wins, m_loses, m_who, m_over_left;
  bit m_over, m_winner, m_loser;

  function automatic exp_t snapshot();
    exp_t e;
    e.count    = m_count;
    e.winner   = m_winner;
    e.loser    = m_loser;
    e.gameover = m_over;
    e.who      = m_who;
    e.wins     = m_wins;
    e.loses    = m_loses;
    return e;
  endfunction

  task automatic model_reset();
    m_count = 0; m_wins = 0; m_loses = 0; m_who = 0;
    m_over = 0; m_over_left = 0; m_winner = 0; m_loser = 0;
  endtask

  task automatic model_edge(input bit i, input bit e, input int mode, input int cin);
    int step, nc;
    m_winner = 0;
    m_loser  = 0;
    if (m_over) begin
      m_over_left--;
      if (m_over_left == 0) begin
        m_over = 0; m_who = 0; m_wins = 0; m_loses = 0;
        m_count = i ? cin : 0;
      end
    end else begin
      if (i) begin
        m_count = cin;
      end else if (e) begin
        step = (mode % 2 == 1) ? BIG_STEP : 1;
        if (mode >= 2) nc = (m_count - step < 0) ? 0 : m_count - step;
        else           nc = (m_count + step > MAXV) ? MAXV : m_count + step;
        m_winner = (nc == MAXV) && (m_count != MAXV);
        m_loser  = (nc == 0) && (m_count != 0);
        m_count  = nc;
      end
      if (m_winner) begin
        m_wins++;
        if (m_wins == WIN_LIMIT) begin m_over = 1; m_over_left = OVER_CYCLES; m_who = 2; end
      end
      if (m_loser) begin
        m_loses++;
        if (m_loses == LOSE_LIMIT) begin m_over = 1; m_over_left = OVER_CYCLES; m_who = 1; end
      end
    end
  endtask

  task automatic compare(input string name, input exp_t e);
    bit bad;
    bad = (int'(count) != e.count) || (winner != e.winner) || (loser != e.loser) ||
          (gameover != e.gameover) || (int'(who) != e.who);
`ifdef MMC_SCORE_OUT_EN
    bad = bad || (int'(win_count) != e.wins) || (int'(lose_count) != e.loses);
`endif
    n_vec++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s @%0t: got count=%0d win=%0b lose=%0b over=%0b who=%0d, want count=%0d win=%0b lose=%0b over=%0b who=%0d (wins=%0d loses=%0d)",
               name, $time, count, winner, loser, gameover, who,
               e.count, e.winner, e.loser, e.gameover, e.who, e.wins, e.loses);
    end
  endtask

  // Driver: inputs change on the falling edge; expectation is for the next rising edge.
  task automatic apply(input bit i, input bit e, input int mode, input int cin);
    @(negedge clk);
    reset_n       = 1'b1;
    init          = i;
    en            = e;
    control_value = 2'(mode);
    count_input   = WIDTH'(cin);
    model_edge(i, e, mode, cin);
    q.push_back(snapshot());
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare(name, snapshot());
  endtask

  // Monitor: every edge with a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        compare("scoreboard", e);
      end
    end
  end

  initial begin
    int wait_cyc;
    reset_n = 1'b1; en = 1'b0; control_value = 2'b00; init = 1'b1; count_input = 4'd9;
    model_reset();
    #2;
    reset_n = 1'b0;
    #3;
    compare("reset_init", snapshot());

    apply(1, 0, 0, 9);                       // load 9
    apply(1, 0, 0, 13);
    repeat (3) apply(0, 1, 0, 0);            // 14, 15 (win), 15
    apply(1, 0, 0, 1);
    apply(0, 1, 3, 0);                       // 1 -> 0 lose
    apply(0, 1, 2, 0);                       // stays 0
    repeat (5) apply(0, 0, 1, 0);            // hold
    apply(1, 1, 0, 7);                       // load beats count
    apply(1, 0, 0, 14); apply(0, 1, 0, 0);   // win 2
    apply(1, 0, 0, 14); apply(0, 1, 1, 0);   // win 3 -> OVER
    apply(0, 1, 2, 3); apply(0, 1, 3, 8);    // frozen
    apply(1, 1, 0, 5);                       // exit reload 5
    apply(1, 0, 0, 1); apply(0, 1, 2, 0);    // lose 1
    apply(1, 0, 0, 2); apply(0, 1, 3, 0);    // lose 2 -> OVER
    apply(0, 1, 0, 0);
    do_reset("reset_mid_over");
    apply(0, 1, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset("reset_random");
      apply(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, MAXV)));
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #5;
    if (q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
